// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART TX FIFO write port between two byte-stream requesters.
// A grant is held for a whole packet, so bytes from different sources never
// interleave on the serial line. Priority alternates between requesters on
// each packet. A stall timeout revokes the grant of an owner that stops
// sending mid-packet.
//
// Optional feature (macro ARB_CRLF_EN): when defined, every completed packet
// is followed by CR (0x0D) and LF (0x0A) written on behalf of the owner.
//
// Parameters:
//   DBIT    data byte width (matches the TX FIFO width)
//   TO_CYC  idle cycles tolerated mid-packet before the grant is revoked (>=1)
//   TO_W    width of the timeout counter (TO_CYC must fit)
//
// Ports:
//   clk           system clock
//   reset         asynchronous reset, active low
//   valid0/1      requester has a byte on data0/1
//   last0/1       that byte ends the requester's packet
//   data0/1       requester bytes
//   ready0/1      byte accepted this cycle when the matching valid is high
//   tx_full       TX FIFO full
//   wr_uart       TX FIFO write strobe
//   w_data        TX FIFO write data
//   gnt           one-hot current owner, 00 when idle
//   busy          high whenever the arbiter is not idle
//   timeout_tick  one-cycle pulse when a grant is revoked by timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int DBIT   = 8,
    parameter int TO_CYC = 1000,
    parameter int TO_W   = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid0,
    input  logic            last0,
    input  logic [DBIT-1:0] data0,
    output logic            ready0,
    input  logic            valid1,
    input  logic            last1,
    input  logic [DBIT-1:0] data1,
    output logic            ready1,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [1:0]      gnt,
    output logic            busy,
    output logic            timeout_tick
);

`ifdef ARB_CRLF_EN
    typedef enum logic [1:0] {IDLE, GRANT, CR, LF} state_t;
`else
    typedef enum logic {IDLE, GRANT} state_t;
`endif

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            rr_q, rr_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic            sel_valid;
    logic            sel_last;
    logic [DBIT-1:0] sel_data;
    logic [1:0]      owner_onehot;

    // Mux the owner's request so the FSM only ever looks at one requester.
    assign sel_valid    = owner_q ? valid1 : valid0;
    assign sel_last     = owner_q ? last1  : last0;
    assign sel_data     = owner_q ? data1  : data0;
    assign owner_onehot = owner_q ? 2'b10  : 2'b01;

    // State, owner, round-robin pointer and stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode. All outputs are zero in IDLE, which is
    // what makes an asynchronous reset clear every output immediately.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        ready0       = 1'b0;
        ready1       = 1'b0;
        wr_uart      = 1'b0;
        w_data       = '0;
        gnt          = 2'b00;
        busy         = 1'b0;
        timeout_tick = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a tie consults the round-robin pointer.
                if (valid0 || valid1) begin
                    owner_d = (valid0 && valid1) ? rr_q : valid1;
                    state_d = GRANT;
                    cnt_d   = '0;
                end
            end

            GRANT: begin
                busy    = 1'b1;
                gnt     = owner_onehot;
                w_data  = sel_data;
                wr_uart = sel_valid & ~tx_full;
                if (owner_q) begin
                    ready1 = ~tx_full;
                end else begin
                    ready0 = ~tx_full;
                end

                // A full FIFO with a byte waiting is backpressure, not a
                // stall, so the counter only runs while the owner is silent.
                if (sel_valid) begin
                    if (!tx_full) begin
                        cnt_d = '0;
                        if (sel_last) begin
                            rr_d = ~owner_q;
`ifdef ARB_CRLF_EN
                            state_d = CR;
`else
                            state_d = IDLE;
`endif
                        end
                    end
                end else if (cnt_q == TO_W'(TO_CYC - 1)) begin
                    timeout_tick = 1'b1;
                    rr_d         = ~owner_q;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef ARB_CRLF_EN
            CR: begin
                busy    = 1'b1;
                gnt     = owner_onehot;
                w_data  = DBIT'(8'h0D);
                wr_uart = ~tx_full;
                if (!tx_full) begin
                    state_d = LF;
                end
            end

            LF: begin
                busy    = 1'b1;
                gnt     = owner_onehot;
                w_data  = DBIT'(8'h0A);
                wr_uart = ~tx_full;
                if (!tx_full) begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. Expected FIFO bytes are queued as
// stimulus is set up; a monitor pops and compares on every write strobe.
// Cycle-level status ({gnt, busy, ready0, ready1, wr_uart, timeout_tick}) is
// compared inline by each scenario task. Built with TO_CYC=4.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid0, last0, valid1, last1, tx_full;
    logic [7:0] data0, data1;
    logic       ready0, ready1, wr_uart, busy, timeout_tick;
    logic [7:0] w_data;
    logic [1:0] gnt;
    logic [6:0] status;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         checks_total  = 0;
    int         checks_passed = 0;

    uart_tx_arbiter #(.DBIT(8), .TO_CYC(4), .TO_W(10)) dut (
        .clk(clk), .reset(reset),
        .valid0(valid0), .last0(last0), .data0(data0), .ready0(ready0),
        .valid1(valid1), .last1(last1), .data1(data1), .ready1(ready1),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .gnt(gnt), .busy(busy), .timeout_tick(timeout_tick)
    );

    always #5 clk = ~clk;

    assign status = {gnt, busy, ready0, ready1, wr_uart, timeout_tick};

    // Scoreboard monitor: every FIFO write must match the next expected byte.
    always @(negedge clk) begin
        if (reset === 1'b1 && wr_uart === 1'b1) begin
            checks_total++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL scoreboard_extra: got w_data=%h, expected no write", w_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (w_data !== mon_exp)
                    $display("[TB] FAIL scoreboard_byte: got w_data=%h, expected %h", w_data, mon_exp);
                else
                    checks_passed++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        valid0 = 1'b0; last0 = 1'b0; data0 = '0;
        valid1 = 1'b0; last1 = 1'b0; data1 = '0;
        tx_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drive_req(input bit req, input logic v, input logic [7:0] d, input logic l);
        if (req) begin
            valid1 = v; data1 = d; last1 = l;
        end else begin
            valid0 = v; data0 = d; last0 = l;
        end
    endtask

    // Valid/ready packet driver; bytes packed MSB-first into a 32-bit word.
    task automatic send_pkt(input bit req, input logic [31:0] bytes, input int n);
        bit ok;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            drive_req(req, 1'b1, bytes[31-8*k -: 8], (k == n - 1));
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if ((req ? ready1 : ready0) === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks_total++;
                $display("[TB] FAIL handshake_req%0d: got no ready in 200 cycles, expected ready", req);
                drive_req(req, 1'b0, 8'h00, 1'b0);
                return;
            end
            @(posedge clk); #1;
        end
        drive_req(req, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_drained(input string name);
        checks_total++;
        if (exp_q.size() != 0)
            $display("[TB] FAIL %s_drained: got %0d bytes left, expected 0", name, exp_q.size());
        else
            checks_passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        valid0 = 1'b0; last0 = 1'b0; data0 = '0;
        valid1 = 1'b0; last1 = 1'b0; data1 = '0;
        tx_full = 1'b0;
        #12;
        checks_total++;
        if (status !== 7'b0000000) $display("[TB] FAIL reset_status: got %b, expected 0000000", status);
        else checks_passed++;
        checks_total++;
        if (w_data !== 8'h00) $display("[TB] FAIL reset_w_data: got %h, expected 00", w_data);
        else checks_passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks_total++;
        if (status !== 7'b0000000) $display("[TB] FAIL reset_release: got %b, expected 0000000", status);
        else checks_passed++;
    endtask

    task automatic test_single();
        exp_q.push_back(8'h1C); exp_q.push_back(8'h32); exp_q.push_back(8'h21);
        @(posedge clk); #1;
        valid0 = 1'b1; data0 = 8'h1C; last0 = 1'b0;
        @(negedge clk);
        checks_total++;
        if (status !== 7'b0000000) $display("[TB] FAIL single_latency: got %b, expected 0000000", status);
        else checks_passed++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) data0 = 8'h32;
            if (k == 2) begin data0 = 8'h21; last0 = 1'b1; end
            @(negedge clk);
            checks_total++;
            if (status !== 7'b0111010) $display("[TB] FAIL single_byte%0d: got %b, expected 0111010", k, status);
            else checks_passed++;
        end
        @(posedge clk); #1;
        valid0 = 1'b0; last0 = 1'b0; data0 = '0;
        @(negedge clk);
        checks_total++;
        if (status !== 7'b0000000) $display("[TB] FAIL single_release: got %b, expected 0000000", status);
        else checks_passed++;
        check_drained("single");
    endtask

    task automatic test_contention();
        pulse_reset();
        exp_q.push_back(8'hAA); exp_q.push_back(8'hAB);
        exp_q.push_back(8'h55); exp_q.push_back(8'h56);
        fork
            send_pkt(1'b0, 32'hAAAB_0000, 2);
            send_pkt(1'b1, 32'h5556_0000, 2);
        join
        exp_q.push_back(8'h10);
        send_pkt(1'b0, 32'h1000_0000, 1);
        exp_q.push_back(8'h55); exp_q.push_back(8'h56);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hAB);
        fork
            send_pkt(1'b0, 32'hAAAB_0000, 2);
            send_pkt(1'b1, 32'h5556_0000, 2);
        join
        check_drained("contention");
    endtask

    task automatic test_backpressure();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        @(posedge clk); #1;
        valid0 = 1'b1; data0 = 8'h01; last0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data0 = 8'h02; tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks_total++;
            if (status !== 7'b0110000) $display("[TB] FAIL backpressure_stall%0d: got %b, expected 0110000", i, status);
            else checks_passed++;
            if (i < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        tx_full = 1'b0;
        @(negedge clk);
        checks_total++;
        if (status !== 7'b0111010) $display("[TB] FAIL backpressure_resume: got %b, expected 0111010", status);
        else checks_passed++;
        @(posedge clk); #1;
        data0 = 8'h03; last0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0; last0 = 1'b0; data0 = '0;
        @(negedge clk);
        check_drained("backpressure");
    endtask

    task automatic test_timeout();
        exp_q.push_back(8'h77); exp_q.push_back(8'h99);
        @(posedge clk); #1;
        valid1 = 1'b1; data1 = 8'h77; last1 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks_total++;
        if (status !== 7'b1010110) $display("[TB] FAIL timeout_accept: got %b, expected 1010110", status);
        else checks_passed++;
        @(posedge clk); #1;
        valid1 = 1'b0; data1 = '0;
        valid0 = 1'b1; data0 = 8'h99; last0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks_total++;
            if (status !== ((i < 4) ? 7'b1010100 : 7'b1010101))
                $display("[TB] FAIL timeout_idle%0d: got %b, expected %b", i, status,
                         ((i < 4) ? 7'b1010100 : 7'b1010101));
            else checks_passed++;
        end
        @(negedge clk);
        checks_total++;
        if (status !== 7'b0000000) $display("[TB] FAIL timeout_release: got %b, expected 0000000", status);
        else checks_passed++;
        @(negedge clk);
        checks_total++;
        if (status !== 7'b0111010) $display("[TB] FAIL timeout_next_grant: got %b, expected 0111010", status);
        else checks_passed++;
        @(posedge clk); #1;
        valid0 = 1'b0; last0 = 1'b0; data0 = '0;
        @(negedge clk);
        check_drained("timeout");
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(8'h01);
        @(posedge clk); #1;
        valid0 = 1'b1; data0 = 8'h01; last0 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        data0 = 8'h02;
        #1;
        checks_total++;
        if (status !== 7'b0111010) $display("[TB] FAIL reset_mid_before: got %b, expected 0111010", status);
        else checks_passed++;
        reset = 1'b0;
        #1;
        checks_total++;
        if (status !== 7'b0000000 || w_data !== 8'h00)
            $display("[TB] FAIL reset_mid_async: got %b/%h, expected 0000000/00", status, w_data);
        else checks_passed++;
        valid0 = 1'b0; data0 = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(8'h5A); exp_q.push_back(8'h6B);
        fork
            send_pkt(1'b0, 32'h5A00_0000, 1);
            send_pkt(1'b1, 32'h6B00_0000, 1);
        join
        check_drained("reset_mid");
    endtask

`ifdef ARB_CRLF_EN
    task automatic test_crlf();
        exp_q.push_back(8'h41); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        @(posedge clk); #1;
        valid0 = 1'b1; data0 = 8'h41; last0 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        valid0 = 1'b0; last0 = 1'b0; data0 = '0; tx_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks_total++;
            if (status !== 7'b0110000) $display("[TB] FAIL crlf_cr_wait%0d: got %b, expected 0110000", i, status);
            else checks_passed++;
        end
        @(posedge clk); #1;
        tx_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks_total++;
            if (status !== 7'b0110010) $display("[TB] FAIL crlf_write%0d: got %b, expected 0110010", i, status);
            else checks_passed++;
        end
        @(negedge clk);
        checks_total++;
        if (status !== 7'b0000000) $display("[TB] FAIL crlf_release: got %b, expected 0000000", status);
        else checks_passed++;
        check_drained("crlf");
    endtask
`endif

    initial begin
        $display("[TB] uart_tx_arbiter bench start");
        test_reset();
`ifdef ARB_CRLF_EN
        test_crlf();
`else
        test_single();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid();
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
